// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t NO_REG = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_e;

  // True when the ID instruction reads a register the load in EX has not produced yet.
  function automatic logic load_use_hit(
    input logic     ex_mem_read,
    input logic     ex_reg_write,
    input reg_idx_t ex_rd,
    input logic     uses_rx,
    input reg_idx_t rx,
    input logic     uses_ry,
    input reg_idx_t ry
  );
    return ex_mem_read && ex_reg_write && (ex_rd != NO_REG) &&
           ((uses_rx && (rx == ex_rd)) || (uses_ry && (ry == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle of the hazard unit; master is the pipeline, slave the hazard unit.
interface hazard_unit_if;
  import hazard_pkg::*;

  reg_idx_t    idRx;
  reg_idx_t    idRy;
  logic        idUsesRx;
  logic        idUsesRy;
  reg_idx_t    exRd;
  logic        exRegWrite;
  logic        exMemRead;
  logic        exBranchTaken;
  logic        memRamAccess;
  logic        counterClear;

  logic        pcWrite;
  logic        ifIdWrite;
  logic        idExWrite;
  logic        exMemWrite;
  logic        ifIdFlush;
  logic        idExFlush;
  logic [15:0] stallCount;
  logic [15:0] flushCount;

  modport master (
    output idRx, idRy, idUsesRx, idUsesRy, exRd, exRegWrite, exMemRead,
           exBranchTaken, memRamAccess, counterClear,
    input  pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush,
           stallCount, flushCount
  );

  modport slave (
    input  idRx, idRy, idUsesRx, idUsesRy, exRd, exRegWrite, exMemRead,
           exBranchTaken, memRamAccess, counterClear,
    output pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush,
           stallCount, flushCount
  );

endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter with synchronous clear (dominant) and saturation at all-ones.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/freeze control for a pipeline whose data RAM is shared with instruction fetch.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input logic          CLK,
  input logic          RST,
  hazard_unit_if.slave hz
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] wait_q;
  logic [3:0] wait_d;

  logic pc_write;
  logic if_id_write;
  logic id_ex_write;
  logic ex_mem_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic branch_flush;
  logic load_use;

  assign load_use = load_use_hit(hz.exMemRead, hz.exRegWrite, hz.exRd,
                                 hz.idUsesRx, hz.idRx, hz.idUsesRy, hz.idRy);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    branch_flush = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.memRamAccess) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          // The entry cycle is itself the first freeze cycle; a one-cycle wait never leaves RUN.
          if (MEM_WAIT > 1) begin
            state_d = FREEZE;
            wait_d  = 4'(MEM_WAIT - 1);
          end
        end else if (hz.exBranchTaken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          branch_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end

      FREEZE: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        if (wait_q <= 4'd1) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign hz.pcWrite    = pc_write;
  assign hz.ifIdWrite  = if_id_write;
  assign hz.idExWrite  = id_ex_write;
  assign hz.exMemWrite = ex_mem_write;
  assign hz.ifIdFlush  = if_id_flush;
  assign hz.idExFlush  = id_ex_flush;

  sat_counter16 u_stall_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (hz.counterClear),
    .inc   (!pc_write),
    .count (hz.stallCount)
  );

  sat_counter16 u_flush_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (hz.counterClear),
    .inc   (branch_flush),
    .count (hz.flushCount)
  );

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, giving the number of freeze cycles per shared-RAM data access (range 1..15).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports idRx, idRy  input  4 each  source register indices of the instruction in ID; 0-7 are GPRs, 8-14 are special registers, 15 (NO_REG) means none.
REQ-005 SHALL have ports idUsesRx, idUsesRy  input  1 each  the ID instruction reads idRx / idRy.
REQ-006 SHALL have ports exRd  input  4, exRegWrite  input  1, exMemRead  input  1  destination and control of the instruction held in the ID/EX register.
REQ-007 SHALL have port exBranchTaken  input  1  a branch or jump resolved taken in EX this cycle.
REQ-008 SHALL have port memRamAccess  input  1  the MEM stage starts a load/store to the RAM shared with instruction fetch.
REQ-009 SHALL have port counterClear  input  1  synchronous clear of both counters.
REQ-010 SHALL have ports pcWrite, ifIdWrite, idExWrite, exMemWrite  output  1 each  stage-register write enables.
REQ-011 SHALL have ports ifIdFlush, idExFlush  output  1 each  load a bubble (all control bits zero) into IF/ID or ID/EX.
REQ-012 SHALL have ports stallCount, flushCount  output  16 each  performance counters.

Function
REQ-013 SHALL implement FSM states RUN and FREEZE plus a 4-bit wait counter.
REQ-014 In RUN with memRamAccess=1, the unit SHALL enter FREEZE with the wait counter set to MEM_WAIT-1 and drive all four write enables low in that same cycle.
REQ-015 In FREEZE, all write enables SHALL be low, both flushes low, and the counter SHALL decrement each cycle; at counter 0 the next state SHALL be RUN.
REQ-016 In FREEZE, exBranchTaken and load-use conditions SHALL be ignored; they are re-evaluated in the first RUN cycle, because the frozen pipeline still presents them.
REQ-017 In RUN, exBranchTaken=1 (with memRamAccess=0) SHALL assert ifIdFlush and idExFlush, with all write enables high, for that one cycle.
REQ-018 Load-use SHALL be defined as exMemRead & exRegWrite & exRd!=NO_REG & ((idUsesRx & idRx==exRd) | (idUsesRy & idRy==exRd)).
REQ-019 In RUN, load-use (with no branch and no memRamAccess) SHALL drive pcWrite=0, ifIdWrite=0, idExFlush=1, idExWrite=1, exMemWrite=1, giving exactly one bubble.
REQ-020 Priority in RUN SHALL be memRamAccess > exBranchTaken > load-use > normal, where normal means all enables high and flushes low.
REQ-021 Control outputs SHALL be combinational from state and inputs, and registered state SHALL change only on CLK.
REQ-022 stallCount SHALL increment on every cycle with pcWrite=0; flushCount SHALL increment on every cycle in which REQ-017 applies.
REQ-023 Both counters SHALL saturate at 16'hFFFF, and counterClear SHALL take priority over incrementing.
REQ-024 With MEM_WAIT=1, FREEZE SHALL last exactly one cycle beyond the entry cycle only if the counter is nonzero; otherwise the entry cycle alone is the freeze, so total freeze length is MEM_WAIT cycles.

Reset
REQ-025 RST low SHALL force state RUN, wait counter 0, and stallCount=flushCount=0 immediately, regardless of CLK.
REQ-026 During reset, outputs SHALL be those of RUN for the current inputs; reset asserted mid-FREEZE SHALL abort the freeze.

Structure
REQ-027 A shared package hazard_pkg SHALL hold the state enum, NO_REG=4'hF, and the 4-bit register-index typedef.
REQ-028 A sub-module sat_counter16 (clear, increment, saturate) SHALL be instantiated twice.

Verification
REQ-029 Load-use: exMemRead=1, exRegWrite=1, exRd=3, idRx=3, idUsesRx=1 -> pcWrite=0, ifIdWrite=0, idExFlush=1 for 1 cycle; stallCount=1.
REQ-030 Branch: exBranchTaken=1 for 1 cycle -> ifIdFlush=idExFlush=1, pcWrite=1; flushCount=1.
REQ-031 Memory freeze: MEM_WAIT=2, memRamAccess=1 pulse -> all enables low for exactly 2 cycles, then RUN; stallCount=2.
REQ-032 Simultaneous events: memRamAccess=1, exBranchTaken=1, and load-use in the same cycle -> freeze first with no flush; after the freeze, the held branch flushes once.
REQ-033 Corner cases: exRd=15 with matching idRx -> no stall; counters preset to 16'hFFFF stay saturated; counterClear gives 0.
REQ-034 Reset: RST low in the second FREEZE cycle -> state RUN and counters 0 asynchronously; enables high when inputs are idle.
